// File: rtl/ram_2r2w_wr_sched.sv
// Write-port scheduler for a 2R/2W RAM: clears the array after reset/init_start,
// then shares both write ports among four round-robin requesters.
`ifndef ADDR_LEN
`define ADDR_LEN 5
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module ram_2r2w_wr_sched #(
   parameter int BRAM_ADDR_WIDTH = `ADDR_LEN,
   parameter int BRAM_DATA_WIDTH = `DATA_LEN,
   parameter int DATA_DEPTH = 32,
   parameter logic [BRAM_DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         init_start,
   output logic                         init_done,
   input  logic [3:0]                   req_valid,
   output logic [3:0]                   req_ready,
   input  logic [4*BRAM_ADDR_WIDTH-1:0] req_addr,
   input  logic [4*BRAM_DATA_WIDTH-1:0] req_data,
   output logic                         we1,
   output logic                         we2,
   output logic [BRAM_ADDR_WIDTH-1:0]   waddr1,
   output logic [BRAM_ADDR_WIDTH-1:0]   waddr2,
   output logic [BRAM_DATA_WIDTH-1:0]   wdata1,
   output logic [BRAM_DATA_WIDTH-1:0]   wdata2
);

   localparam int AW = BRAM_ADDR_WIDTH;
   localparam int DW = BRAM_DATA_WIDTH;
   localparam logic [AW-1:0] LAST = AW'(DATA_DEPTH - 2);

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [AW-1:0] ptr_q;
   logic [1:0]    rr_q;

   logic [AW-1:0] a_addr [4];
   logic [DW-1:0] a_data [4];

   logic          run_go;
   logic          ga_v;
   logic          gb_v;
   logic [1:0]    ga;
   logic [1:0]    gb;
   logic [1:0]    idx;

   for (genvar g = 0; g < 4; g++) begin : g_unpack
      assign a_addr[g] = req_addr[g*AW +: AW];
      assign a_data[g] = req_data[g*DW +: DW];
   end

   assign init_done = (state_q == S_RUN);
   assign run_go    = (state_q == S_RUN) && !init_start;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_INIT;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT: begin
            if (!init_start && ptr_q == LAST) state_d = S_RUN;
         end
         S_RUN: begin
            if (init_start) state_d = S_INIT;
         end
         default: state_d = S_INIT;
      endcase
   end

   // B must differ in address from A so the two ports never collide
   always_comb begin
      ga_v = 1'b0;
      gb_v = 1'b0;
      ga   = 2'd0;
      gb   = 2'd0;
      idx  = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_q + 2'(k);
         if (run_go && req_valid[idx]) begin
            if (!ga_v) begin
               ga_v = 1'b1;
               ga   = idx;
            end else if (!gb_v && a_addr[idx] != a_addr[ga]) begin
               gb_v = 1'b1;
               gb   = idx;
            end
         end
      end
   end

   always_comb begin
      req_ready = 4'b0000;
      if (ga_v) req_ready[ga] = 1'b1;
      if (gb_v) req_ready[gb] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q  <= '0;
         rr_q   <= 2'd0;
         we1    <= 1'b0;
         we2    <= 1'b0;
         waddr1 <= '0;
         waddr2 <= '0;
         wdata1 <= '0;
         wdata2 <= '0;
      end else begin
         we1 <= 1'b0;
         we2 <= 1'b0;
         if (init_start) begin
            ptr_q <= '0;
         end else if (state_q == S_INIT) begin
            we1    <= 1'b1;
            we2    <= 1'b1;
            waddr1 <= ptr_q;
            waddr2 <= ptr_q + AW'(1);
            wdata1 <= INIT_VALUE;
            wdata2 <= INIT_VALUE;
            ptr_q  <= ptr_q + AW'(2);
         end else begin
            if (ga_v) begin
               we1    <= 1'b1;
               waddr1 <= a_addr[ga];
               wdata1 <= a_data[ga];
               rr_q   <= (gb_v ? gb : ga) + 2'd1;
            end
            if (gb_v) begin
               we2    <= 1'b1;
               waddr2 <= a_addr[gb];
               wdata2 <= a_data[gb];
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_2r2w_wr_sched.sv
// Random and directed traffic against a queue-based arbitration model and a
// reference memory image; a simple 2W RAM model sits on the write ports.
module tb_ram_2r2w_wr_sched;

   localparam int AW = 5;
   localparam int DW = 16;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          init_start = 1'b0;
   logic          init_done;
   logic [3:0]    req_valid = 4'b0000;
   logic [3:0]    req_ready;
   logic [AW-1:0] ad [4];
   logic [DW-1:0] dt [4];
   logic [4*AW-1:0] req_addr;
   logic [4*DW-1:0] req_data;
   logic          we1, we2;
   logic [AW-1:0] waddr1, waddr2;
   logic [DW-1:0] wdata1, wdata2;

   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   int            rr_m = 0;
   int            n_vec = 0;
   int            n_err = 0;

   assign req_addr = {ad[3], ad[2], ad[1], ad[0]};
   assign req_data = {dt[3], dt[2], dt[1], dt[0]};

   ram_2r2w_wr_sched #(
      .BRAM_ADDR_WIDTH(AW),
      .BRAM_DATA_WIDTH(DW),
      .DATA_DEPTH(DEPTH),
      .INIT_VALUE(16'h0000)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .init_start(init_start),
      .init_done(init_done),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr(req_addr),
      .req_data(req_data),
      .we1(we1),
      .we2(we2),
      .waddr1(waddr1),
      .waddr2(waddr2),
      .wdata1(wdata1),
      .wdata2(wdata2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (we1) ram[waddr1] <= wdata1;
      if (we2) ram[waddr2] <= wdata2;
   end

   always @(posedge clk) begin
      if (reset_n)
         assert (!(we1 && we2 && waddr1 == waddr2))
         else $error("FAIL samaddr_assert addr=%0d", waddr1);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: timeout, got no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic refill(input int lo_pct);
      for (int i = 0; i < 4; i++) begin
         if (!req_valid[i] && $urandom_range(99) < 50 + lo_pct) begin
            req_valid[i] = 1'b1;
            if ($urandom_range(3) == 0) ad[i] = AW'($urandom_range(DEPTH-1));
            else                        ad[i] = AW'($urandom_range(7));
            dt[i] = DW'($urandom);
         end
      end
   endtask

   task automatic step();
      int q[$];
      int a;
      int b;
      logic [3:0] er;
      a  = -1;
      b  = -1;
      er = 4'b0000;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         if (req_valid[(rr_m + k) % 4]) q.push_back((rr_m + k) % 4);
      end
      if (q.size() > 0) a = q[0];
      foreach (q[j]) begin
         if (j > 0 && b < 0 && ad[q[j]] != ad[a]) b = q[j];
      end
      if (a >= 0) er[a] = 1'b1;
      if (b >= 0) er[b] = 1'b1;
      check("ready", req_ready, er);
      @(posedge clk);
      #1;
      check("we1", we1, a >= 0);
      check("we2", we2, b >= 0);
      if (a >= 0) check("wr1", {waddr1, wdata1}, {ad[a], dt[a]});
      if (b >= 0) check("wr2", {waddr2, wdata2}, {ad[b], dt[b]});
      check("samaddr", we1 && we2 && waddr1 == waddr2, 0);
      if (a >= 0) begin
         ref_mem[ad[a]] = dt[a];
         req_valid[a] = 1'b0;
         rr_m = ((b >= 0 ? b : a) + 1) % 4;
      end
      if (b >= 0) begin
         ref_mem[ad[b]] = dt[b];
         req_valid[b] = 1'b0;
      end
   endtask

   task automatic sweep_check();
      for (int i = 0; i < DEPTH / 2; i++) begin
         @(negedge clk);
         check("sweep_rdy", req_ready, 0);
         check("sweep_done", init_done, 0);
         @(posedge clk);
         #1;
         check("sweep_we", {we1, we2}, 2'b11);
         check("sweep_addr", {waddr1, waddr2}, {AW'(2*i), AW'(2*i+1)});
         check("sweep_data", {wdata1, wdata2}, 0);
      end
      check("init_done", init_done, 1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask

   task automatic drain_cmp(input string tag);
      for (int i = 0; i < 40 && req_valid != 0; i++) step();
      check("drain", req_valid, 0);
      step();
      for (int i = 0; i < DEPTH; i++) check(tag, ram[i], ref_mem[i]);
   endtask

   task automatic rand_run(input int n);
      for (int i = 0; i < n; i++) begin
         refill($urandom_range(40));
         step();
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         ad[i] = '0;
         dt[i] = '0;
      end
      // reset state
      #12;
      check("rst_we", {we1, we2}, 0);
      check("rst_addr", {waddr1, waddr2}, 0);
      check("rst_data", {wdata1, wdata2}, 0);
      check("rst_rdy", req_ready, 0);
      check("rst_done", init_done, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      req_valid = 4'($urandom);
      sweep_check();
      req_valid = 4'b0000;

      // all four valid, distinct addresses
      ad[0] = 5'd3; ad[1] = 5'd5; ad[2] = 5'd7; ad[3] = 5'd9;
      for (int i = 0; i < 4; i++) dt[i] = DW'($urandom);
      req_valid = 4'b1111;
      step();
      step();

      // same-address conflict
      ad[0] = 5'd6; dt[0] = 16'h000A;
      ad[1] = 5'd6; dt[1] = 16'h000B;
      req_valid = 4'b0011;
      step();
      step();
      step();
      check("rd6", ram[6], 16'h000B);

      // lone requester 2
      ad[2] = 5'd4; dt[2] = 16'h1234;
      req_valid = 4'b0100;
      step();
      ad[3] = 5'd1; dt[3] = 16'h0031;
      ad[0] = 5'd2; dt[0] = 16'h0032;
      req_valid = 4'b1001;
      step();

      rand_run(400);
      drain_cmp("mem_a");

      // init_start beats pending requests
      req_valid = 4'b0000;
      refill(100);
      @(negedge clk);
      init_start = 1'b1;
      #1;
      check("istart_rdy", req_ready, 0);
      @(posedge clk);
      #1;
      init_start = 1'b0;
      check("istart_we", {we1, we2}, 0);
      sweep_check();
      begin
         logic [3:0] held;
         held = req_valid;
         req_valid = 4'b0000;
         step();
         for (int i = 0; i < DEPTH; i++) check("mem_clr", ram[i], 0);
         req_valid = held;
      end
      rand_run(100);
      drain_cmp("mem_b");

      // reset mid-sweep
      init_start = 1'b1;
      @(posedge clk);
      #1;
      init_start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_addr", {we1, waddr1}, {1'b1, 5'd8});
      reset_n = 1'b0;
      #1;
      check("mid_rst_we", {we1, we2}, 0);
      check("mid_rst_done", init_done, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      rr_m = 0;
      sweep_check();
      rand_run(200);
      drain_cmp("mem_c");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
